scanchain_bitstream_shifter: RTL and testbench

SCANCHAIN_BITSTREAM_SHIFTER -- requirements
Module: scanchain_bitstream_shifter

---
 rtl/scanchain_bitstream_shifter_pkg.sv | 25 ++
 rtl/scanchain_bitstream_shifter_if.sv | 33 +++
 rtl/scanchain_tick_sync.sv | 39 +++
 rtl/scanchain_bitstream_shifter.sv | 118 +++++++++++
 tb/tb_scanchain_bitstream_shifter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/scanchain_bitstream_shifter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scanchain_bitstream_shifter_pkg : state encoding and default sizing (rev 1.0)
// ----------------------------------------------------------------------------
package scanchain_bitstream_shifter_pkg;

  localparam int unsigned DEFAULT_CHAIN_LENGTH = 6140;
  localparam int unsigned DEFAULT_WORD_WIDTH   = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH   = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int unsigned words_needed(input int unsigned bits,
                                               input int unsigned width);
    return (bits + width - 1) / width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scanchain_bitstream_shifter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scanchain_bitstream_shifter_if : control, memory and scan-chain bundle (rev 1.0)
// ----------------------------------------------------------------------------
interface scanchain_bitstream_shifter_if
  import scanchain_bitstream_shifter_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  start;
  logic                  shift_tick;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_rdata;
  logic                  chain_head;
  logic                  chain_shift_en;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, shift_tick, mem_rdata,
    output mem_rd_en, mem_addr, chain_head, chain_shift_en, busy, done
  );

  modport slave (
    output start, shift_tick, mem_rdata,
    input  mem_rd_en, mem_addr, chain_head, chain_shift_en, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/scanchain_tick_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scanchain_tick_sync : start edge detector and one-deep pending tick (rev 1.0)
// ----------------------------------------------------------------------------
module scanchain_tick_sync (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic start,
  input  wire logic shift_tick,
  input  wire logic capture_en,
  input  wire logic shift_en,
  output logic      start_rise,
  output logic      tick_accept
);

  logic start_q, start_d;
  logic pending_q, pending_d;

  // A tick seen while the word is being fetched is parked until shifting resumes.
  always_comb begin
    start_d   = start;
    pending_d = capture_en & (pending_q | shift_tick);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      start_q   <= start_d;
      pending_q <= pending_d;
    end
  end

  assign start_rise  = start & ~start_q;
  assign tick_accept = shift_en & (shift_tick | pending_q);

endmodule
`default_nettype wire

// File: rtl/scanchain_bitstream_shifter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scanchain_bitstream_shifter : streams memory words MSB-first into a scan chain (rev 1.0)
// ----------------------------------------------------------------------------
module scanchain_bitstream_shifter
  import scanchain_bitstream_shifter_pkg::*;
#(
  parameter int unsigned CHAIN_LENGTH = DEFAULT_CHAIN_LENGTH,
  parameter int unsigned WORD_WIDTH   = DEFAULT_WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
  input  wire logic                      sys_clk,
  input  wire logic                      reset,
  scanchain_bitstream_shifter_if.master  bus
);

  localparam int unsigned c_total_w = $clog2(CHAIN_LENGTH + 1);
  localparam int unsigned c_bit_w   = $clog2(WORD_WIDTH + 1);
  localparam logic [c_total_w-1:0]  c_last_bit  = c_total_w'(CHAIN_LENGTH - 1);
  localparam logic [c_bit_w-1:0]    c_last_slot = c_bit_w'(WORD_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_last_word =
      ADDR_WIDTH'(words_needed(CHAIN_LENGTH, WORD_WIDTH) - 1);

  state_e                state_q,   state_d;
  logic [WORD_WIDTH-1:0] shreg_q,   shreg_d;
  logic [c_bit_w-1:0]    bit_cnt_q, bit_cnt_d;
  logic [c_total_w-1:0]  total_q,   total_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic                  head_q,    head_d;

  logic start_rise;
  logic tick_accept;
  logic capture_en;
  logic shift_en;

  assign capture_en = (state_q == ST_FETCH) || (state_q == ST_LOAD);
  assign shift_en   = (state_q == ST_SHIFT);

  scanchain_tick_sync u_tick_sync (
    .clk         (sys_clk),
    .rst         (reset),
    .start       (bus.start),
    .shift_tick  (bus.shift_tick),
    .capture_en  (capture_en),
    .shift_en    (shift_en),
    .start_rise  (start_rise),
    .tick_accept (tick_accept)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    total_d   = total_q;
    addr_d    = addr_q;
    head_d    = head_q;
    unique case (state_q)
      ST_IDLE: begin
        addr_d  = '0;
        total_d = '0;
        if (start_rise) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        shreg_d   = bus.mem_rdata;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick_accept) begin
          head_d    = shreg_q[WORD_WIDTH-1];
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + c_bit_w'(1);
          total_d   = total_q + c_total_w'(1);
          // Chain-length check wins, so a partial last word is never drained.
          if (total_q == c_last_bit) begin
            state_d = ST_DONE;
          end else if ((bit_cnt_q == c_last_slot) && (addr_q != c_last_word)) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        if (!bus.start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      total_q   <= '0;
      addr_q    <= '0;
      head_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      total_q   <= total_d;
      addr_q    <= addr_d;
      head_q    <= head_d;
    end
  end

  // The new bit is presented in the same cycle as its shift-enable pulse.
  assign bus.chain_head     = tick_accept ? shreg_q[WORD_WIDTH-1] : head_q;
  assign bus.chain_shift_en = tick_accept;
  assign bus.mem_rd_en      = (state_q == ST_FETCH);
  assign bus.mem_addr       = addr_q;
  assign bus.busy           = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign bus.done           = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_scanchain_bitstream_shifter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_scanchain_bitstream_shifter : bit-sequence model bench, 16-bit and 12-bit chains (rev 1.0)
// ----------------------------------------------------------------------------
module tb_scanchain_bitstream_shifter;

  localparam int P_RST       = 1;
  localparam int P_SEQ_A53C  = 2;
  localparam int P_B12       = 3;
  localparam int P_IDLE_A    = 4;
  localparam int P_PEND      = 5;
  localparam int P_SEQ_5AC3  = 6;
  localparam int P_HOLD      = 7;
  localparam int P_RST_OUT   = 8;
  localparam int P_DROP_DONE = 9;

  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b, tick;

  always #5 clk = ~clk;

  scanchain_bitstream_shifter_if #(.WORD_WIDTH(8), .ADDR_WIDTH(2)) if_a ();
  scanchain_bitstream_shifter_if #(.WORD_WIDTH(8), .ADDR_WIDTH(2)) if_b ();

  scanchain_bitstream_shifter #(.CHAIN_LENGTH(16), .WORD_WIDTH(8), .ADDR_WIDTH(2)) dut_a (
    .sys_clk (clk),
    .reset   (reset),
    .bus     (if_a.master)
  );

  scanchain_bitstream_shifter #(.CHAIN_LENGTH(12), .WORD_WIDTH(8), .ADDR_WIDTH(2)) dut_b (
    .sys_clk (clk),
    .reset   (reset),
    .bus     (if_b.master)
  );

  assign if_a.start      = start_a;
  assign if_b.start      = start_b;
  assign if_a.shift_tick = tick;
  assign if_b.shift_tick = tick;

  logic [7:0] mem [2][4];

  always @(posedge clk) begin
    if (if_a.mem_rd_en) if_a.mem_rdata <= mem[0][if_a.mem_addr];
    if (if_b.mem_rd_en) if_b.mem_rdata <= mem[1][if_b.mem_addr];
  end

  // Model state: owned by the compare process only.
  int          checks = 0;
  int          errors = 0;
  int          idx[2]      = '{0, 0};
  int          rd_cnt[2]   = '{0, 0};
  int          max_addr[2] = '{0, 0};
  int          seen_id[2]  = '{0, 0};
  logic [15:0] cap[2]      = '{16'h0, 16'h0};
  int          lit_seen    = 0;
  int          clen[2]     = '{16, 12};

  // Requests: owned by the driver process only.
  int load_id[2] = '{0, 0};
  int lit_seq    = 0;
  int lit_phase  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nwords(input int d);
    return (clen[d] + 7) / 8;
  endfunction

  function automatic logic exp_bit(input int d, input int i);
    logic [7:0] w;
    w = mem[d][i / 8];
    return w[7 - (i % 8)];
  endfunction

  task automatic clear_model(input int d);
    idx[d] = 0; rd_cnt[d] = 0; max_addr[d] = 0; cap[d] = '0;
  endtask

  task automatic model_step(input int d, input logic sh, input logic head, input logic rd,
                            input logic [1:0] addr, input logic busy, input logic done);
    chk($sformatf("addr_range%0d", d), (int'(addr) <= nwords(d) - 1), 1);
    if (int'(addr) > max_addr[d]) max_addr[d] = int'(addr);
    if (sh) begin
      chk($sformatf("shift_busy%0d", d), busy, 1);
      chk($sformatf("shift_in_range%0d", d), (idx[d] < clen[d]), 1);
      if (idx[d] < clen[d]) chk($sformatf("chain_head%0d_bit%0d", d, idx[d]), head, exp_bit(d, idx[d]));
      cap[d] = {cap[d][14:0], head};
      idx[d]++;
    end
    if (rd) begin
      chk($sformatf("rd_addr%0d", d), addr, rd_cnt[d]);
      chk($sformatf("rd_in_range%0d", d), (rd_cnt[d] < nwords(d)), 1);
      rd_cnt[d]++;
    end
    if (done) begin
      chk($sformatf("done_bits%0d", d), idx[d], clen[d]);
      chk($sformatf("done_not_busy%0d", d), busy, 0);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        clear_model(d);
        seen_id[d] = load_id[d];
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (load_id[d] != seen_id[d]) begin
          clear_model(d);
          seen_id[d] = load_id[d];
        end
      end
      model_step(0, if_a.chain_shift_en, if_a.chain_head, if_a.mem_rd_en, if_a.mem_addr, if_a.busy, if_a.done);
      model_step(1, if_b.chain_shift_en, if_b.chain_head, if_b.mem_rd_en, if_b.mem_addr, if_b.busy, if_b.done);
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        case (lit_phase)
          P_RST, P_RST_OUT: begin
            chk("rst_head_a", if_a.chain_head, 0);  chk("rst_shen_a", if_a.chain_shift_en, 0);
            chk("rst_rden_a", if_a.mem_rd_en, 0);   chk("rst_addr_a", if_a.mem_addr, 0);
            chk("rst_busy_a", if_a.busy, 0);        chk("rst_done_a", if_a.done, 0);
            chk("rst_head_b", if_b.chain_head, 0);  chk("rst_shen_b", if_b.chain_shift_en, 0);
            chk("rst_rden_b", if_b.mem_rd_en, 0);   chk("rst_addr_b", if_b.mem_addr, 0);
            chk("rst_busy_b", if_b.busy, 0);        chk("rst_done_b", if_b.done, 0);
          end
          P_SEQ_A53C, P_SEQ_5AC3, P_DROP_DONE: begin
            chk("seq_bits_a", cap[0], (lit_phase == P_SEQ_5AC3) ? 16'h5AC3 : 16'hA53C);
            chk("seq_pulses_a", idx[0], 16);
            chk("seq_done_a", if_a.done, 1);
            chk("seq_busy_a", if_a.busy, 0);
            chk("seq_reads_a", rd_cnt[0], 2);
            chk("seq_maxaddr_a", max_addr[0], 1);
            chk("seq_head_hold_a", if_a.chain_head, (lit_phase == P_SEQ_5AC3) ? 1 : 0);
          end
          P_B12: begin
            chk("seq_bits_b", cap[1][11:0], 12'hFF0);
            chk("seq_pulses_b", idx[1], 12);
            chk("seq_reads_b", rd_cnt[1], 2);
            chk("seq_maxaddr_b", max_addr[1], 1);
            chk("seq_done_b", if_b.done, 1);
          end
          P_IDLE_A: begin
            chk("idle_done_a", if_a.done, 0);
            chk("idle_busy_a", if_a.busy, 0);
          end
          P_PEND: begin
            chk("pend_shen_a", if_a.chain_shift_en, 1);
            chk("pend_head_a", if_a.chain_head, 0);
            chk("pend_busy_a", if_a.busy, 1);
          end
          P_HOLD: begin
            chk("hold_done_a", if_a.done, 1);
            chk("hold_busy_a", if_a.busy, 0);
            chk("hold_rden_a", if_a.mem_rd_en, 0);
            chk("hold_reads_a", rd_cnt[0], 2);
          end
          default: chk("lit_phase_known", lit_phase, 0);
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int p);
    lit_phase = p;
    lit_seq++;
  endtask

  // Pulses tick `count` times, `period` cycles apart; returns one cycle after the last pulse.
  task automatic train(input int count, input int period);
    for (int i = 0; i < count; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (i != count - 1) repeat (period - 1) step();
    end
  endtask

  task automatic set_mem(input int d, input logic [7:0] w0, input logic [7:0] w1);
    mem[d][0] = w0; mem[d][1] = w1; mem[d][2] = 8'hEE; mem[d][3] = 8'hEE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; tick = 1'b0;
    set_mem(0, 8'hA5, 8'h3C);
    set_mem(1, 8'hFF, 8'h0F);
    repeat (3) step();
    reset = 1'b0;
    req(P_RST); step();

    // Basic 16-bit and 12-bit loads side by side, first tick in SHIFT.
    load_id[0]++; load_id[1]++; step();
    start_a = 1'b1; start_b = 1'b1;
    repeat (3) step();
    train(16, 8);
    req(P_SEQ_A53C); step();
    req(P_B12); step();
    start_a = 1'b0; start_b = 1'b0; step();
    req(P_IDLE_A); step();

    // First tick lands in FETCH, then start held high through DONE.
    set_mem(0, 8'h5A, 8'hC3);
    load_id[0]++; step();
    start_a = 1'b1; step();
    tick = 1'b1; step();
    tick = 1'b0; step();
    req(P_PEND);
    repeat (5) step();
    train(15, 8);
    req(P_SEQ_5AC3);
    repeat (50) step();
    req(P_HOLD); step();
    start_a = 1'b0; step();
    req(P_IDLE_A); step();

    // Identical second load, first tick lands in LOAD.
    load_id[0]++; step();
    start_a = 1'b1; step(); step();
    tick = 1'b1; step();
    tick = 1'b0;
    repeat (6) step();
    train(15, 8);
    req(P_SEQ_5AC3); step();
    start_a = 1'b0; step();

    // Reset after five bits, then a full restart from address 0.
    set_mem(0, 8'hA5, 8'h3C);
    load_id[0]++; step();
    start_a = 1'b1;
    repeat (3) step();
    train(5, 8);
    reset = 1'b1; start_a = 1'b0; step();
    reset = 1'b0;
    req(P_RST_OUT); step();
    load_id[0]++; step();
    start_a = 1'b1;
    repeat (3) step();
    train(16, 8);
    req(P_SEQ_A53C); step();
    start_a = 1'b0; step();

    // Start dropped mid-SHIFT: load completes, DONE for one cycle, then IDLE.
    load_id[0]++; step();
    start_a = 1'b1;
    repeat (3) step();
    train(5, 8);
    start_a = 1'b0;
    repeat (6) step();
    train(11, 8);
    req(P_DROP_DONE); step();
    req(P_IDLE_A); step();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
